// File: rtl/frame_phase_tracker.sv
// Frame phase tracker for frame_aligner.
// Watches the start-of-frame markers, locks onto the first one and then runs a
// 3-bit clock phase counter plus a half-phase bit (0 = frame starts on d0,
// 1 = frame starts on d1). It tells the aligner when a complete frame sits in
// the lane shift registers, and raises a sticky error on any framing anomaly.
//
// Ports
//   clock           : sampling clock, rising edge
//   reset_n         : asynchronous active-low reset
//   sot_d0, sot_d1  : start-of-frame markers for the d0 / d1 sample
//   emit            : a full frame is ready this cycle (capture at this edge)
//   emit_half       : locked frame starts on d1 (selects the capture window)
//   alignment_error : sticky framing error
module frame_phase_tracker #(
  parameter int unsigned DDR = 1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic sot_d0,
  input  logic sot_d1,
  output logic emit,
  output logic emit_half,
  output logic alignment_error
);

  localparam logic StUnlocked = 1'b0;
  localparam logic StLocked   = 1'b1;

  logic       state_q, state_d;
  logic [2:0] phase_q, phase_d;
  logic       half_q, half_d;
  logic       armed_q, armed_d;
  logic       err_q, err_d;

  logic mark0, mark1, any_mark, relock;

  always_comb begin
    // sot_d0 wins when both markers fire together.
    mark0    = sot_d0;
    mark1    = (DDR != 0) && sot_d1 && !sot_d0;
    any_mark = mark0 | mark1;

    state_d = state_q;
    phase_d = phase_q + 3'd1;
    half_d  = half_q;
    armed_d = armed_q;
    err_d   = err_q;
    emit    = 1'b0;
    relock  = 1'b0;

    if ((DDR != 0) && sot_d0 && sot_d1) begin
      err_d = 1'b1;
    end

    if (state_q == StUnlocked) begin
      phase_d = '0;
      if (any_mark) begin
        state_d = StLocked;
        relock  = 1'b1;
      end
    end else if (phase_q == 3'd0) begin
      // Expected boundary: a missing marker keeps the phase, a marker on the
      // wrong half re-locks to it.
      if (!any_mark) begin
        err_d = 1'b1;
      end else if (mark1 != half_q) begin
        err_d  = 1'b1;
        relock = 1'b1;
      end
    end else if (any_mark) begin
      err_d  = 1'b1;
      relock = 1'b1;
    end

    if (relock) begin
      // The marker cycle is phase 0, so the next cycle is phase 1.
      phase_d = 3'd1;
      half_d  = mark1;
      armed_d = 1'b0;
    end else if (state_q == StLocked) begin
      if (phase_q == 3'd7) begin
        armed_d = 1'b1;
      end
      // A d1-started frame ends on d0 of the following phase-0 cycle; armed_q
      // keeps that from firing in the very first marker cycle.
      emit = half_q ? ((phase_q == 3'd0) && armed_q) : (phase_q == 3'd7);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StUnlocked;
      phase_q <= '0;
      half_q  <= 1'b0;
      armed_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      half_q  <= half_d;
      armed_q <= armed_d;
      err_q   <= err_d;
    end
  end

  assign emit_half       = half_q;
  assign alignment_error = err_q;

endmodule

// File: rtl/frame_aligner.sv
// Frame aligner: assembles 8-clock frames from 8 sample lanes.
// Each lane shifts its samples into a W-bit register (oldest sample at bit 0).
// When the phase tracker reports a complete frame, the W-sample window that
// starts at the marked sample is copied into sbits for every lane.
//
// Ports
//   clock           : 320 MHz sampling clock, rising edge
//   reset_n         : asynchronous active-low reset
//   d0, d1          : per-lane samples, d0 first in time; d1 unused when DDR=0
//   sot_d0, sot_d1  : start-of-frame markers for d0 / d1; sot_d1 unused when DDR=0
//   sbits           : assembled frame, lane i at bits [i*W +: W], held between frames
//   frame_valid     : one-cycle strobe, sbits updated this cycle
//   alignment_error : sticky framing error
module frame_aligner #(
  parameter int unsigned DDR = 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [7:0]          d0,
  input  logic [7:0]          d1,
  input  logic                sot_d0,
  input  logic                sot_d1,
  output logic [64*DDR+63:0]  sbits,
  output logic                frame_valid,
  output logic                alignment_error
);

  localparam int unsigned Lanes       = 8;
  localparam int unsigned FrameClocks = 8;
  localparam int unsigned W           = FrameClocks * (DDR + 1);

  logic                 emit;
  logic                 emit_half;
  logic [Lanes*W-1:0]   frame_win;
  logic [Lanes*W-1:0]   sbits_q;
  logic                 frame_valid_q;

  frame_phase_tracker #(
    .DDR (DDR)
  ) u_tracker (
    .clock           (clock),
    .reset_n         (reset_n),
    .sot_d0          (sot_d0),
    .sot_d1          (sot_d1),
    .emit            (emit),
    .emit_half       (emit_half),
    .alignment_error (alignment_error)
  );

  for (genvar i = 0; i < Lanes; i++) begin : g_lane
    logic [W-1:0] sr_q, sr_d;

    if (DDR != 0) begin : g_ddr
      assign sr_d = {d1[i], d0[i], sr_q[W-1:2]};
      // d1-started frame: drop the oldest sample and append this cycle's d0.
      assign frame_win[i*W +: W] = emit_half ? {d0[i], sr_q[W-1:1]} : sr_d;
    end else begin : g_sdr
      logic unused_ddr_inputs;
      assign unused_ddr_inputs   = ^{d1[i], emit_half};
      assign sr_d                = {d0[i], sr_q[W-1:1]};
      assign frame_win[i*W +: W] = sr_d;
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        sr_q <= '0;
      end else begin
        sr_q <= sr_d;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sbits_q       <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      frame_valid_q <= emit;
      if (emit) begin
        sbits_q <= frame_win;
      end
    end
  end

  assign sbits       = sbits_q;
  assign frame_valid = frame_valid_q;

endmodule

// File: tb/tb_frame_aligner.sv
// Scoreboard bench for frame_aligner: one DDR=1 and one DDR=0 instance.
// Stimulus pushes the expected frame and its visible cycle when it issues a
// marker; a negedge monitor pops and compares whenever frame_valid is high.
module tb_frame_aligner;

  typedef struct {
    logic [127:0] data;
    int           cyc;
  } exp_t;

  localparam logic [127:0] Cc = {8{16'hCCCC}};
  localparam logic [127:0] S6 = {8{16'h6666}};
  localparam logic [127:0] S3 = {8{16'h3333}};
  localparam logic [127:0] L3 = 128'h00000000FF000000;
  localparam logic [127:0] Wk = 128'h8040201008040201;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [7:0]   d0_1 = '0, d1_1 = '0, d0_0 = '0, d1_0 = '0;
  logic         s0_1 = 1'b0, s1_1 = 1'b0, s0_0 = 1'b0, s1_0 = 1'b0;
  logic [127:0] sbits1;
  logic [63:0]  sbits0;
  logic         fv1, fv0, err1, err0;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic par1 = 1'b0;
  exp_t q1[$];
  exp_t q0[$];
  exp_t m1, m0;

  frame_aligner #(.DDR(1)) dut1 (
    .clock           (clock),
    .reset_n         (reset_n),
    .d0              (d0_1),
    .d1              (d1_1),
    .sot_d0          (s0_1),
    .sot_d1          (s1_1),
    .sbits           (sbits1),
    .frame_valid     (fv1),
    .alignment_error (err1)
  );

  frame_aligner #(.DDR(0)) dut0 (
    .clock           (clock),
    .reset_n         (reset_n),
    .d0              (d0_0),
    .d1              (d1_0),
    .sot_d0          (s0_0),
    .sot_d1          (s1_0),
    .sbits           (sbits0),
    .frame_valid     (fv0),
    .alignment_error (err0)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: every frame_valid must match the oldest expectation, data and cycle.
  always @(negedge clock) begin
    if (reset_n && fv1) begin
      if (q1.size() == 0) begin
        check("dut1_unexpected_frame", 128'(fv1), 128'(0));
      end else begin
        m1 = q1.pop_front();
        check("dut1_sbits", sbits1, m1.data);
        check("dut1_frame_cycle", 128'(cyc), 128'(m1.cyc));
      end
    end
    if (reset_n && fv0) begin
      if (q0.size() == 0) begin
        check("dut0_unexpected_frame", 128'(fv0), 128'(0));
      end else begin
        m0 = q0.pop_front();
        check("dut0_sbits", 128'(sbits0), m0.data);
        check("dut0_frame_cycle", 128'(cyc), 128'(m0.cyc));
      end
    end
  end

  // DDR=1 step: lanes alternate 00 / FF per clock, both samples equal.
  task automatic step1(input logic s0, input logic s1, input logic push,
                       input logic [127:0] val, input int lat);
    exp_t e;
    d0_1 = par1 ? 8'hFF : 8'h00;
    d1_1 = d0_1;
    s0_1 = s0;
    s1_1 = s1;
    if (push) begin
      e.data = val;
      e.cyc  = cyc + lat;
      q1.push_back(e);
    end
    @(posedge clock);
    #1;
    par1 = !par1;
    s0_1 = 1'b0;
    s1_1 = 1'b0;
  endtask

  // DDR=0 step; d1 and sot_d1 carry junk that must be ignored.
  task automatic step0(input logic [7:0] d, input logic s0, input logic s1,
                       input logic push, input logic [127:0] val);
    exp_t e;
    d0_0 = d;
    d1_0 = 8'($urandom);
    s0_0 = s0;
    s1_0 = s1;
    if (push) begin
      e.data = val;
      e.cyc  = cyc + 8;
      q0.push_back(e);
    end
    @(posedge clock);
    #1;
    s0_0 = 1'b0;
    s1_0 = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("rst_sbits1", sbits1, 128'(0));
    check("rst_fv1", 128'(fv1), 128'(0));
    check("rst_err1", 128'(err1), 128'(0));
    check("rst_sbits0", 128'(sbits0), 128'(0));
    check("rst_fv0", 128'(fv0), 128'(0));
    check("rst_err0", 128'(err0), 128'(0));
    check("q1_drained", 128'(q1.size()), 128'(0));
    check("q0_drained", 128'(q0.size()), 128'(0));
    q1.delete();
    q0.delete();
    @(posedge clock);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Lock on sot_d0 at a 00 clock: every lane 0xCCCC.
    par1 = 1'b0;
    for (int f = 0; f < 4; f++)
      for (int c = 0; c < 8; c++) step1(c == 0, 1'b0, c == 0, Cc, 8);
    check("A_err_clean", 128'(err1), 128'(0));
    step1(1'b0, 1'b0, 1'b0, '0, 0);
    check("A_missing_marker_err", 128'(err1), 128'(1));
    do_reset();

    // Lock on sot_d1: frame one sample later, 0x6666, visible at c0+9.
    par1 = 1'b0;
    for (int f = 0; f < 3; f++)
      for (int c = 0; c < 8; c++) step1(1'b0, c == 0, c == 0, S6, 9);
    check("B_err_clean", 128'(err1), 128'(0));
    step1(1'b0, 1'b0, 1'b0, '0, 0);
    step1(1'b0, 1'b0, 1'b0, '0, 0);
    do_reset();

    // Marker moved by 3 clocks onto an FF clock: re-lock, data 0x3333.
    par1 = 1'b0;
    for (int f = 0; f < 2; f++)
      for (int c = 0; c < 8; c++) step1(c == 0, 1'b0, c == 0, Cc, 8);
    step1(1'b0, 1'b0, 1'b0, '0, 0);
    check("C_missing_err", 128'(err1), 128'(1));
    step1(1'b0, 1'b0, 1'b0, '0, 0);
    step1(1'b0, 1'b0, 1'b0, '0, 0);
    for (int f = 0; f < 2; f++)
      for (int c = 0; c < 8; c++) step1(c == 0, 1'b0, c == 0, S3, 8);
    check("C_err_sticky", 128'(err1), 128'(1));
    step1(1'b0, 1'b0, 1'b0, '0, 0);
    do_reset();

    // Both markers together: error, framing follows sot_d0 (0xCCCC, not 0x6666).
    // Then reset mid-frame: the partial frame never appears.
    par1 = 1'b0;
    step1(1'b1, 1'b1, 1'b1, Cc, 8);
    for (int c = 1; c < 8; c++) step1(1'b0, 1'b0, 1'b0, '0, 0);
    check("D_dual_marker_err", 128'(err1), 128'(1));
    step1(1'b1, 1'b0, 1'b0, '0, 0);
    for (int c = 0; c < 3; c++) step1(1'b0, 1'b0, 1'b0, '0, 0);
    do_reset();
    for (int c = 0; c < 12; c++) step1(1'b0, 1'b0, 1'b0, '0, 0);
    par1 = 1'b0;
    step1(1'b1, 1'b0, 1'b1, Cc, 8);
    for (int c = 1; c < 8; c++) step1(1'b0, 1'b0, 1'b0, '0, 0);
    check("D_err_after_reset", 128'(err1), 128'(0));
    step1(1'b0, 1'b0, 1'b0, '0, 0);
    do_reset();

    // DDR=0: lane 3 constant high, then a walking bit (lane i high at sample i).
    for (int f = 0; f < 3; f++)
      for (int c = 0; c < 8; c++) step0(8'h08, c == 0, c == 4, c == 0, L3);
    for (int f = 0; f < 2; f++)
      for (int c = 0; c < 8; c++) step0(8'(1 << c), c == 0, 1'b0, c == 0, Wk);
    check("E_err_clean", 128'(err0), 128'(0));
    step0(8'h00, 1'b0, 1'b0, 1'b0, '0);

    check("final_q1_empty", 128'(q1.size()), 128'(0));
    check("final_q0_empty", 128'(q0.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_aligner.md
FRAME_ALIGNER -- requirements
Module: frame_aligner

Interface
REQ-001 Parameter: DDR, default 1, 1 = two samples per lane per clock (d0 then d1), 0 = one sample per lane per clock (d0 only).
REQ-002 Port clock  input  1  single fast sampling clock (320 MHz); one clock, all logic on its rising edge.
REQ-003 Port reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port d0  input  8  per-lane sample, first-in-time sample of each clock (lane i = bit i).
REQ-005 Port d1  input  8  per-lane sample, second-in-time sample of each clock; ignored when DDR=0.
REQ-006 Port sot_d0  input  1  start-of-frame marker coincident with d0 sample.
REQ-007 Port sot_d1  input  1  start-of-frame marker coincident with d1 sample; ignored when DDR=0.
REQ-008 Port sbits  output  64*DDR+64  assembled frame, registered.
REQ-009 Port frame_valid  output  1  one-cycle strobe, sbits updated this cycle.
REQ-010 Port alignment_error  output  1  sticky framing-error flag.

Function
REQ-011 A frame SHALL be 8 clocks long: W = 8*(DDR+1) bits per lane, 8 lanes.
REQ-012 Sample stream per lane SHALL be ordered d0(c), d1(c), d0(c+1), ... (DDR=1) or d0(c), d0(c+1), ... (DDR=0).
REQ-013 Frame start SHALL be the sample flagged by sot_d0 or (DDR=1) sot_d1; that sample is lane bit 0.
REQ-014 sbits[i*W + k] SHALL be the k-th sample of lane i counted from frame start, k = 0..W-1.
REQ-015 Frame start on d0 of cycle c0: last sample captured in cycle c0+7; sbits and frame_valid SHALL update at the edge ending c0+7 (visible in cycle c0+8).
REQ-016 Frame start on d1 of cycle c0 (DDR=1): frame spans d1(c0)..d0(c0+8); sbits and frame_valid SHALL be visible in cycle c0+9.
REQ-017 sbits SHALL hold its value between frame_valid strobes.
REQ-018 State: UNLOCKED (initial) and LOCKED; a 3-bit phase counter plus a 1-bit half-phase (d0/d1) record the frame boundary.
REQ-019 UNLOCKED: first marker seen -> LOCKED, phase set, that frame captured; no frame_valid before first marker.
REQ-020 LOCKED: frames SHALL be emitted every 8 clocks from the locked phase regardless of further markers.
REQ-021 LOCKED: marker absent at an expected boundary, or present at any other sample position -> alignment_error set, aligner re-locks to the new marker position (if any) and the partial frame in progress is discarded.
REQ-022 sot_d0 and sot_d1 both high in the same cycle -> alignment_error set, sot_d0 wins.
REQ-023 A missing marker at the expected boundary SHALL set alignment_error but keep current phase and continue emitting frames.
REQ-024 alignment_error SHALL remain set until reset_n asserted.

Reset
REQ-025 reset_n low SHALL immediately force sbits=0, frame_valid=0, alignment_error=0, state UNLOCKED, phase counter and partial shift registers to 0.
REQ-026 Reset mid-frame SHALL discard the partial frame; after release, capture restarts at the next marker.

Structure
REQ-027 No shared package; frame length (8) and lane count (8) are local constants.
REQ-028 One natural sub-module: frame_phase_tracker (marker checking, phase counter, lock/error state); per-lane shift registers remain in frame_aligner.
REQ-029 Target 120-400 lines RTL; DDR selects logic via generate, no unused d1 flops when DDR=0.

Verification
REQ-030 DDR=1, all lanes alternate 0,0 / 1,1 per clock, sot_d0 every 8 clocks on a 0,0 cycle -> after lock every lane = 0xCCCC, sbits = 0xCCCC repeated 8x, frame_valid every 8th clock, alignment_error=0.
REQ-031 DDR=1, same data, marker moved to sot_d1 one half-cycle later -> frame shifted by one sample, each lane = 0x6666, alignment_error=0 (no prior lock).
REQ-032 DDR=0, lane i constant 1 only for i=3, sot_d0 period 8 -> sbits = 64'h00000000FF000000, frame_valid period 8.
REQ-033 Locked, marker moved by 3 clocks -> alignment_error=1 and stays 1, next frame_valid 8 clocks after new marker, data realigned.
REQ-034 Locked, reset_n pulsed low mid-frame -> sbits=0, frame_valid=0, alignment_error=0 immediately; first frame_valid 8 clocks after next marker.
REQ-035 sot_d0 and sot_d1 high together -> alignment_error=1, framing follows sot_d0.
